// File: rtl/bit_packer.sv
// bit_packer
// Packs variable-length codes (0..15 bits each) into 32-bit words, MSB first.
// The earliest code bit lands in dataout[31]. A flush emits any held bits as
// a partial word, with the unused low-order bits filled with PAD_BIT.
//
// Ports:
//   clock    - sole clock, rising edge
//   reset    - asynchronous, active-low
//   pushin   - a code is presented this cycle
//   lenin    - code length in bits (0 = no-op)
//   datain   - right-justified code value; bits at and above lenin ignored
//   flushin  - emit held bits as a padded partial word
//   pushout  - one-cycle pulse per emitted word
//   dataout  - packed word
//   validout - number of meaningful bits in dataout (0 when pushout=0)
module bit_packer #(
    parameter logic PAD_BIT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pushin,
    input  logic [3:0]  lenin,
    input  logic [14:0] datain,
    input  logic        flushin,
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  validout
);

    typedef enum logic {ACC, FLUSHPEND} state_t;

    state_t      state;
    logic [46:0] acc;
    logic [4:0]  cnt;
    logic        flush_req;

    logic [3:0]  len_eff;
    logic [14:0] code;
    logic [5:0]  total;
    logic [5:0]  shamt;
    logic [46:0] merged;
    logic [46:0] fresh;
    logic        do_flush;

    // Held bits live left-aligned in acc (acc[46] is the oldest bit). A new
    // code is shifted so that its MSB sits directly below the held bits.
    // flush_req carries a flush that arrived together with a push during
    // FLUSHPEND: that push cannot join the pending remainder, so its flush is
    // applied on the following cycle instead.
    always_comb begin
        len_eff  = pushin ? lenin : 4'd0;
        code     = datain & ~(15'h7FFF << len_eff);
        total    = {1'b0, cnt} + {2'b00, len_eff};
        shamt    = 6'd47 - total;
        merged   = acc | ({32'd0, code} << shamt);
        fresh    = {32'd0, code} << (6'd47 - {2'b00, len_eff});
        do_flush = flushin | flush_req;
    end

    function automatic logic [31:0] pad_word(input logic [31:0] bits, input logic [5:0] n);
        logic [31:0] fill;
        fill = 32'hFFFF_FFFF >> n;
        return PAD_BIT ? (bits | fill) : bits;
    endfunction

    // Main state machine. All outputs are registered, so a word completed by
    // the push at one edge appears on pushout during the following cycle.
    // In FLUSHPEND the remainder of an overflowing flush goes out alone and
    // any push in that cycle starts a fresh accumulator.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            flush_req <= 1'b0;
            pushout   <= 1'b0;
            dataout   <= '0;
            validout  <= '0;
        end else begin
            pushout  <= 1'b0;
            dataout  <= '0;
            validout <= '0;
            case (state)
                FLUSHPEND: begin
                    pushout   <= 1'b1;
                    dataout   <= pad_word(acc[46:15], {1'b0, cnt});
                    validout  <= {1'b0, cnt};
                    acc       <= fresh;
                    cnt       <= {1'b0, len_eff};
                    flush_req <= flushin && (len_eff != 4'd0);
                    state     <= ACC;
                end
                default: begin
                    flush_req <= 1'b0;
                    if (total >= 6'd32) begin
                        pushout  <= 1'b1;
                        dataout  <= merged[46:15];
                        validout <= 6'd32;
                        acc      <= merged << 32;
                        // total is 32..46 here, so total-32 is just its low bits.
                        cnt      <= total[4:0];
                        if (do_flush && total != 6'd32)
                            state <= FLUSHPEND;
                    end else if (do_flush && total != 6'd0) begin
                        pushout  <= 1'b1;
                        dataout  <= pad_word(merged[46:15], total);
                        validout <= total;
                        acc      <= '0;
                        cnt      <= '0;
                    end else begin
                        acc <= merged;
                        cnt <= total[4:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer
// Drives two bit_packer instances (PAD_BIT 0 and 1) with the same directed
// and random stimulus and compares them against a bit-queue reference model.
module tb_bit_packer;

    logic        clock;
    logic        reset;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flushin;
    logic        po0, po1;
    logic [31:0] do0, do1;
    logic [5:0]  vo0, vo1;

    int checks = 0;
    int errors = 0;

    bit          q[$];
    bit          m_fp;
    bit          m_freq;
    logic        exp_push;
    logic [31:0] exp_word;
    logic [5:0]  exp_valid;

    bit_packer #(.PAD_BIT(1'b0)) dut_pad0 (
        .clock(clock), .reset(reset), .pushin(pushin), .lenin(lenin),
        .datain(datain), .flushin(flushin),
        .pushout(po0), .dataout(do0), .validout(vo0)
    );

    bit_packer #(.PAD_BIT(1'b1)) dut_pad1 (
        .clock(clock), .reset(reset), .pushin(pushin), .lenin(lenin),
        .datain(datain), .flushin(flushin),
        .pushout(po1), .dataout(do1), .validout(vo1)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops n bits from the front of the queue into a left-aligned word.
    task automatic emit(input int n);
        exp_word = '0;
        for (int i = 0; i < n; i++)
            exp_word[31-i] = q.pop_front();
        exp_push  = 1'b1;
        exp_valid = 6'(n);
    endtask

    task automatic append(input int len, input logic [14:0] d);
        for (int i = len - 1; i >= 0; i--)
            q.push_back(d[i]);
    endtask

    // Reference behaviour for one clock edge, expressed on a queue of bits.
    task automatic model_step(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
        int len;
        bit eff;
        len       = p ? int'(l) : 0;
        exp_push  = 1'b0;
        exp_valid = '0;
        exp_word  = '0;
        if (m_fp) begin
            emit(q.size());
            m_fp = 1'b0;
            append(len, d);
            m_freq = f && (len > 0);
        end else begin
            eff    = f || m_freq;
            m_freq = 1'b0;
            append(len, d);
            if (q.size() >= 32) begin
                emit(32);
                m_fp = eff && (q.size() > 0);
            end else if (eff && q.size() > 0) begin
                emit(q.size());
            end
        end
    endtask

    task automatic check_output(input string tag);
        logic [31:0] padded;
        padded = exp_word;
        for (int i = int'(exp_valid); i < 32; i++)
            padded[31-i] = 1'b1;
        check_val($sformatf("%s_push0", tag), 32'(po0), 32'(exp_push));
        check_val($sformatf("%s_valid0", tag), 32'(vo0), 32'(exp_valid));
        check_val($sformatf("%s_push1", tag), 32'(po1), 32'(exp_push));
        check_val($sformatf("%s_valid1", tag), 32'(vo1), 32'(exp_valid));
        if (exp_push) begin
            check_val($sformatf("%s_data0", tag), do0, exp_word);
            check_val($sformatf("%s_data1", tag), do1, padded);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, update the model at
    // the rising edge, and sample the outputs at the next falling edge.
    task automatic apply_stimulus(input logic p, input logic [3:0] l, input logic [14:0] d,
                                  input logic f, input string tag);
        pushin  = p;
        lenin   = l;
        datain  = d;
        flushin = f;
        @(posedge clock);
        model_step(p, l, d, f);
        @(negedge clock);
        pushin  = 1'b0;
        lenin   = '0;
        datain  = '0;
        flushin = 1'b0;
        check_output(tag);
    endtask

    // Asserts reset between edges, checks that outputs clear immediately,
    // and releases it on a falling edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check_val($sformatf("%s_rst_push", tag), 32'(po0), 32'd0);
        check_val($sformatf("%s_rst_data", tag), do0, 32'd0);
        check_val($sformatf("%s_rst_valid", tag), 32'(vo0), 32'd0);
        q.delete();
        m_fp      = 1'b0;
        m_freq    = 1'b0;
        exp_push  = 1'b0;
        exp_word  = '0;
        exp_valid = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        reset   = 1'b0;
        pushin  = 1'b0;
        lenin   = '0;
        datain  = '0;
        flushin = 1'b0;
        m_fp    = 1'b0;
        m_freq  = 1'b0;
        #1;
        check_val("init_push", 32'(po0), 32'd0);
        check_val("init_valid", 32'(vo0), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        $display("[TB] reset released");

        // Full word from three pushes.
        apply_stimulus(1, 4'd15, 15'h7FFF, 0, "r029_a");
        apply_stimulus(1, 4'd15, 15'h0000, 0, "r029_b");
        apply_stimulus(1, 4'd2,  15'h0003, 0, "r029_c");
        check_val("r029_data", do0, 32'hFFFE_0003);
        check_val("r029_valid", 32'(vo0), 32'd32);
        apply_stimulus(0, 4'd0, 15'h0, 0, "r029_idle");

        // Partial word flush, single pulse.
        apply_stimulus(1, 4'd4, 15'h000A, 0, "r030_a");
        apply_stimulus(0, 4'd0, 15'h0, 1, "r030_flush");
        check_val("r030_data", do0, 32'hA000_0000);
        check_val("r030_valid", 32'(vo0), 32'd4);
        apply_stimulus(0, 4'd0, 15'h0, 0, "r030_after");

        // Flush with overflow: full word then remainder.
        apply_stimulus(1, 4'd15, 15'h0, 0, "r031_a");
        apply_stimulus(1, 4'd15, 15'h0, 0, "r031_b");
        apply_stimulus(1, 4'd4,  15'hF, 1, "r031_c");
        check_val("r031_word", do0, 32'h0000_0003);
        check_val("r031_wvalid", 32'(vo0), 32'd32);
        apply_stimulus(0, 4'd0, 15'h0, 0, "r031_d");
        check_val("r031_rem", do0, 32'hC000_0000);
        check_val("r031_rvalid", 32'(vo0), 32'd2);
        apply_stimulus(0, 4'd0, 15'h0, 0, "r031_e");
        check_val("r031_quiet", 32'(po0), 32'd0);

        // Push during FLUSHPEND starts a fresh accumulator.
        apply_stimulus(1, 4'd15, 15'h0, 0, "r032_a");
        apply_stimulus(1, 4'd15, 15'h0, 0, "r032_b");
        apply_stimulus(1, 4'd4,  15'hF, 1, "r032_c");
        apply_stimulus(1, 4'd3,  15'h5, 0, "r032_d");
        check_val("r032_rem", do0, 32'hC000_0000);
        apply_stimulus(0, 4'd0, 15'h0, 0, "r032_e");
        apply_stimulus(0, 4'd0, 15'h0, 1, "r032_f");
        check_val("r032_data", do0, 32'hA000_0000);
        check_val("r032_valid", 32'(vo0), 32'd3);

        // Flush during FLUSHPEND together with a push: the push follows alone.
        apply_stimulus(1, 4'd15, 15'h1234, 0, "fpf_a");
        apply_stimulus(1, 4'd15, 15'h4321, 0, "fpf_b");
        apply_stimulus(1, 4'd7,  15'h55,   1, "fpf_c");
        apply_stimulus(1, 4'd5,  15'h13,   1, "fpf_d");
        apply_stimulus(0, 4'd0,  15'h0,    0, "fpf_e");
        apply_stimulus(0, 4'd0,  15'h0,    0, "fpf_f");

        // Reset while a word is on the outputs and bits are held.
        apply_stimulus(1, 4'd15, 15'h7FFF, 0, "r033_a");
        apply_stimulus(1, 4'd15, 15'h7FFF, 0, "r033_b");
        apply_stimulus(1, 4'd15, 15'h7FFF, 0, "r033_c");
        do_reset("r033_busy");
        apply_stimulus(1, 4'd15, 15'h7FFF, 0, "r033_d");
        apply_stimulus(1, 4'd5,  15'h001F, 0, "r033_e");
        do_reset("r033_cnt20");
        apply_stimulus(0, 4'd0, 15'h0, 1, "r033_flush");
        check_val("r033_nopush", 32'(po0), 32'd0);

        // Upper datain bits ignored; zero-length push with flush at cnt=0.
        apply_stimulus(1, 4'd3, 15'h7FF5, 1, "r034_a");
        check_val("r034_data", do0, 32'hA000_0000);
        check_val("r034_valid", 32'(vo0), 32'd3);
        apply_stimulus(1, 4'd0, 15'h1234, 1, "r034_b");
        check_val("r034_nopush", 32'(po0), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            apply_stimulus(r < 7, 4'($urandom_range(0, 15)), 15'($urandom),
                           $urandom_range(0, 5) == 0, "rand");
        end
        apply_stimulus(0, 4'd0, 15'h0, 1, "drain_a");
        apply_stimulus(0, 4'd0, 15'h0, 1, "drain_b");
        apply_stimulus(0, 4'd0, 15'h0, 0, "drain_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
